// File: rtl/pkt_pattern_gen.sv
// Packet test-pattern source for a FIFO write port: fixed-length bursts separated by
// programmable idle gaps, honouring almost-full, with four selectable data patterns.
module pkt_pattern_gen #(
    parameter int          DATA_W      = 128,
    parameter int          PKT_LEN     = 128,
    parameter int          GAP_LEN     = 22,
    parameter logic [31:0] DATA_OFFSET = 32'h0,
    parameter logic [31:0] LFSR_SEED   = 32'hACE1_0001
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic              al_full,
    output logic [DATA_W-1:0] din,
    output logic              wr_en,
    output logic              wr_last,
    output logic [31:0]       pkt_cnt,
    output logic              busy
);
    localparam int LANES  = DATA_W / 32;
    localparam int BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam int GAP_W  = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
    localparam int WALK_W = $clog2(DATA_W);

    localparam logic [DATA_W-1:0] INC_BASE  = DATA_W'(DATA_OFFSET) << (DATA_W - 32);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);
    localparam logic [GAP_W-1:0]  LAST_GAP  = GAP_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
    localparam logic [WALK_W-1:0] LAST_WALK = WALK_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t              state;
    logic [1:0]          pkt_mode;
    logic [BEAT_W-1:0]   beat;
    logic [GAP_W-1:0]    gap;
    logic [WALK_W-1:0]   walk_pos;
    logic [DATA_W-1:0]   inc_word;
    logic [31:0]         lfsr;
    logic [31:0]         lfsr_next;
    logic [DATA_W-1:0]   walk;
    logic [DATA_W-1:0]   pattern;
    logic                last_beat;

    assign last_beat = (beat == LAST_BEAT);
    assign busy      = (state != IDLE);

    // Fibonacci LFSR for x^32+x^22+x^2+x+1, shifting left with feedback into bit 0.
    always_comb begin
        lfsr_next = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
    end

    always_comb begin
        walk           = '0;
        walk[walk_pos] = 1'b1;
        case (pkt_mode)
            2'd0:    pattern = inc_word;
            2'd1:    pattern = {LANES{lfsr}};
            2'd2:    pattern = walk;
            default: pattern = {LANES{pkt_cnt}};
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            pkt_mode <= 2'd0;
            beat     <= '0;
            gap      <= '0;
            walk_pos <= '0;
            inc_word <= INC_BASE;
            lfsr     <= LFSR_SEED;
            din      <= '0;
            wr_en    <= 1'b0;
            wr_last  <= 1'b0;
            pkt_cnt  <= '0;
        end else begin
            wr_en   <= 1'b0;
            wr_last <= 1'b0;
            case (state)
                IDLE: begin
                    if (en) begin
                        state    <= BURST;
                        pkt_mode <= mode;
                        beat     <= '0;
                        walk_pos <= '0;
                    end
                end
                BURST: begin
                    if (!al_full) begin
                        wr_en   <= 1'b1;
                        wr_last <= last_beat;
                        din     <= pattern;
                        // Only the pattern in use advances; the others keep their state.
                        case (pkt_mode)
                            2'd0:    inc_word <= inc_word + 1'b1;
                            2'd1:    lfsr <= lfsr_next;
                            default: ;
                        endcase
                        if (last_beat) begin
                            pkt_cnt  <= pkt_cnt + 1'b1;
                            beat     <= '0;
                            walk_pos <= '0;
                            if (GAP_LEN > 0) begin
                                state <= GAP;
                                gap   <= '0;
                            end else if (en) begin
                                pkt_mode <= mode;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            beat     <= beat + 1'b1;
                            walk_pos <= (walk_pos == LAST_WALK) ? '0 : walk_pos + 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (gap == LAST_GAP) begin
                        if (en) begin
                            state    <= BURST;
                            pkt_mode <= mode;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        gap <= gap + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pkt_pattern_gen.sv
// Bench for pkt_pattern_gen: directed burst/stall/enable/reset sequences and random traffic
// checked against a beat-level model, plus a vector table on a one-beat, no-gap instance.
module tb_pkt_pattern_gen;
    localparam int          DW    = 128;
    localparam int          PL    = 128;
    localparam int          GL    = 22;
    localparam logic [31:0] OFS   = 32'h0;
    localparam logic [31:0] SEED  = 32'hACE1_0001;
    localparam int          LANES = DW / 32;
    localparam logic [DW-1:0] INC_BASE = {OFS, {(DW - 32){1'b0}}};

    logic          clk;
    logic          rst_n, en, al_full;
    logic [1:0]    mode;
    logic [DW-1:0] din;
    logic          wr_en, wr_last, busy;
    logic [31:0]   pkt_cnt;

    logic          rst2_n, en2, af2;
    logic [1:0]    mode2;
    logic [31:0]   din2;
    logic          wr_en2, wr_last2, busy2;
    logic [31:0]   pkt_cnt2;

    int checks   = 0;
    int failures = 0;

    pkt_pattern_gen #(.DATA_W(DW), .PKT_LEN(PL), .GAP_LEN(GL), .DATA_OFFSET(OFS),
                      .LFSR_SEED(SEED)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .al_full(al_full),
        .din(din), .wr_en(wr_en), .wr_last(wr_last), .pkt_cnt(pkt_cnt), .busy(busy)
    );

    pkt_pattern_gen #(.DATA_W(32), .PKT_LEN(1), .GAP_LEN(0), .DATA_OFFSET(32'h100),
                      .LFSR_SEED(SEED)) dut_short (
        .clk(clk), .rst_n(rst2_n), .en(en2), .mode(mode2), .al_full(af2),
        .din(din2), .wr_en(wr_en2), .wr_last(wr_last2), .pkt_cnt(pkt_cnt2), .busy(busy2)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog act=running exp=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        int   taps[4];
        logic fb;
        taps = '{32, 22, 2, 1};
        fb   = 1'b0;
        foreach (taps[i]) fb ^= s[taps[i] - 1];
        return {s[30:0], fb};
    endfunction

    // ---------------- reference model (beat level) ----------------
    localparam int PH_IDLE = 0, PH_SEND = 1, PH_GAP = 2;
    logic [DW-1:0] exp_q[$];
    bit            m_valid = 0;
    int            m_phase, m_beat, m_gap_left, pkt_beats;
    logic [1:0]    m_mode;
    logic [31:0]   m_cnt, m_lfsr;
    logic [DW-1:0] m_inc, m_din;
    logic          m_wr_en, m_last;
    logic          s_rst, s_en, s_af;
    logic [1:0]    s_mode;

    function automatic logic [DW-1:0] model_pattern();
        case (m_mode)
            2'd0:    return m_inc;
            2'd1:    return {LANES{m_lfsr}};
            2'd2:    return DW'(1) << (m_beat % DW);
            default: return {LANES{m_cnt}};
        endcase
    endfunction

    task automatic model_step(input logic r, input logic e, input logic [1:0] md, input logic af);
        if (!r) begin
            m_valid = 1; m_phase = PH_IDLE; m_beat = 0; m_gap_left = 0; m_mode = 2'd0;
            m_cnt = 0; m_lfsr = SEED; m_inc = INC_BASE; m_din = '0;
            m_wr_en = 0; m_last = 0;
            exp_q.delete();
            return;
        end
        m_wr_en = 0;
        m_last  = 0;
        if (m_phase == PH_IDLE) begin
            if (e) begin m_phase = PH_SEND; m_mode = md; m_beat = 0; end
        end else if (m_phase == PH_SEND) begin
            if (!af) begin
                m_din   = model_pattern();
                exp_q.push_back(m_din);
                m_wr_en = 1;
                m_last  = (m_beat == PL - 1);
                if (m_mode == 2'd0) m_inc = m_inc + 1;
                if (m_mode == 2'd1) m_lfsr = lfsr_step(m_lfsr);
                m_beat++;
                if (m_beat == PL) begin
                    m_cnt  = m_cnt + 1;
                    m_beat = 0;
                    if (GL > 0) begin m_phase = PH_GAP; m_gap_left = GL; end
                    else if (e) m_mode = md;
                    else m_phase = PH_IDLE;
                end
            end
        end else begin
            m_gap_left--;
            if (m_gap_left == 0) begin
                if (e) begin m_phase = PH_SEND; m_mode = md; end
                else m_phase = PH_IDLE;
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    always @(posedge clk) begin
        s_rst = rst_n; s_en = en; s_mode = mode; s_af = al_full;
        #1;
        model_step(s_rst, s_en, s_mode, s_af);
        if (m_valid) begin
            chk("wr_en", DW'(wr_en), DW'(m_wr_en));
            chk("wr_last", DW'(wr_last), DW'(m_last));
            chk("pkt_cnt", DW'(pkt_cnt), DW'(m_cnt));
            chk("busy", DW'(busy), DW'(m_phase != PH_IDLE));
            if (wr_en && exp_q.size() > 0) chk("din", din, exp_q.pop_front());
            else chk("din_hold", din, m_din);
            exp_q.delete();
            if (wr_last) chk("last_needs_en", DW'(wr_en), DW'(1));
            if (!s_rst) pkt_beats = 0;
            else if (wr_en) begin
                pkt_beats++;
                if (wr_last) begin
                    chk("pkt_len", DW'(pkt_beats), DW'(PL));
                    pkt_beats = 0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL timeout_%s act=expired exp=event", name);
    endtask

    task automatic wait_wr(input int n, input string name);
        int seen, cyc;
        seen = 0; cyc = 0;
        while (seen < n && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (wr_en) seen++;
        end
        if (seen < n) timeout(name);
    endtask

    task automatic wait_last(input string name);
        int cyc;
        bit hit;
        cyc = 0; hit = 0;
        while (!hit && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            hit = wr_en && wr_last;
        end
        if (!hit) timeout(name);
    endtask

    typedef struct {
        logic        en;
        logic [1:0]  mode;
        logic        af;
        logic        wr_en;
        logic        wr_last;
        logic [31:0] din;
        logic [31:0] cnt;
        logic        busy;
    } vec_t;
    vec_t vt[13];

    // ---------------- stimulus ----------------
    initial begin
        int idle;
        rst_n = 0; en = 0; mode = 0; al_full = 0;
        rst2_n = 0; en2 = 0; mode2 = 0; af2 = 0;
        vt[0]  = '{1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 32'h0,        32'd0, 1'b1};
        vt[1]  = '{1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 32'h0,        32'd1, 1'b1};
        vt[2]  = '{1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 32'h100,      32'd2, 1'b1};
        vt[3]  = '{1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 32'h100,      32'd2, 1'b1};
        vt[4]  = '{1'b1, 2'd3, 1'b0, 1'b1, 1'b1, 32'h101,      32'd3, 1'b1};
        vt[5]  = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 32'h3,        32'd4, 1'b0};
        vt[6]  = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 32'h3,        32'd4, 1'b0};
        vt[7]  = '{1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 32'h3,        32'd4, 1'b1};
        vt[8]  = '{1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 32'h1,        32'd5, 1'b1};
        vt[9]  = '{1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 32'h1,        32'd6, 1'b1};
        vt[10] = '{1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 32'hACE10001, 32'd7, 1'b1};
        vt[11] = '{1'b0, 2'd1, 1'b0, 1'b1, 1'b1, 32'h59C20003, 32'd8, 1'b0};
        vt[12] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 32'h59C20003, 32'd8, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst_din", din, '0);
        chk("rst_wr_en", DW'(wr_en), '0);
        chk("rst_pkt_cnt", DW'(pkt_cnt), '0);
        chk("rst_busy", DW'(busy), '0);

        // T1: incrementing data, start latency, gap length
        rst_n = 1; en = 1; mode = 2'd0;
        @(negedge clk);
        chk("t1_latency", DW'(wr_en), '0);
        @(negedge clk);
        chk("t1_first_en", DW'(wr_en), DW'(1));
        chk("t1_first_din", din, INC_BASE);
        wait_last("t1_last");
        chk("t1_cnt", DW'(pkt_cnt), DW'(1));
        idle = 0;
        @(negedge clk);
        while (!wr_en && idle < 100) begin idle++; @(negedge clk); end
        chk("t1_gap", DW'(idle), DW'(GL));
        chk("t1_second_din", din, INC_BASE + DW'(PL));

        // T2: almost-full stall at beat 40
        wait_wr(39, "t2_beats");
        al_full = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t2_stall", DW'(wr_en), '0);
        end
        al_full = 0;
        @(negedge clk);
        chk("t2_resume", din, INC_BASE + DW'(PL + 40));

        // T3: LFSR pattern
        mode = 2'd1;
        wait_last("t3_last");
        wait_wr(1, "t3_first");
        chk("t3_lfsr_first", din, {LANES{SEED}});
        wait_wr(1, "t3_second");
        chk("t3_lfsr_second", din, {LANES{lfsr_step(SEED)}});
        wait_wr(1000, "t3_run");

        // T4: en drop mid-packet, mode switch taking effect next packet
        mode = 2'd0;
        wait_last("t4_prev");
        wait_wr(10, "t4_beats");
        en = 0; mode = 2'd2;
        wait_last("t4_last");
        repeat (30) @(negedge clk);
        chk("t4_idle_busy", DW'(busy), '0);
        chk("t4_idle_wr_en", DW'(wr_en), '0);
        en = 1;
        wait_wr(1, "t4_walk0");
        chk("t4_walk0", din, DW'(1));
        wait_wr(1, "t4_walk1");
        chk("t4_walk1", din, DW'(2));

        // T6: reset mid-packet
        wait_wr(58, "t6_beats");
        rst_n = 0;
        @(negedge clk);
        chk("t6_din", din, '0);
        chk("t6_wr_en", DW'(wr_en), '0);
        chk("t6_wr_last", DW'(wr_last), '0);
        chk("t6_pkt_cnt", DW'(pkt_cnt), '0);
        chk("t6_busy", DW'(busy), '0);
        rst_n = 1; en = 1; mode = 2'd0;
        @(negedge clk);
        chk("t6_latency", DW'(wr_en), '0);
        @(negedge clk);
        chk("t6_restart_din", din, INC_BASE);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst_n   = ($urandom_range(0, 599) != 0);
            en      = ($urandom_range(0, 7) != 0);
            mode    = 2'($urandom_range(0, 3));
            al_full = ($urandom_range(0, 3) == 0);
        end
        @(negedge clk);
        rst_n = 1; en = 0; al_full = 0;

        // T5: one-beat packets, no gap, vector table
        chk("t5_rst_din", DW'(din2), '0);
        chk("t5_rst_wr_en", DW'(wr_en2), '0);
        chk("t5_rst_cnt", DW'(pkt_cnt2), '0);
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            rst2_n = 1; en2 = vt[i].en; mode2 = vt[i].mode; af2 = vt[i].af;
            @(posedge clk);
            #1;
            chk($sformatf("t5_wr_en_%0d", i), DW'(wr_en2), DW'(vt[i].wr_en));
            chk($sformatf("t5_wr_last_%0d", i), DW'(wr_last2), DW'(vt[i].wr_last));
            chk($sformatf("t5_din_%0d", i), DW'(din2), DW'(vt[i].din));
            chk($sformatf("t5_cnt_%0d", i), DW'(pkt_cnt2), DW'(vt[i].cnt));
            chk($sformatf("t5_busy_%0d", i), DW'(busy2), DW'(vt[i].busy));
        end

        // ---------------- report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
